// File: rtl/regsel_pkg.sv
// rtl/regsel_pkg.sv - command, source-select codes and state enum for regsel_seq
// REGSEL_SEQ_SWAP_EN selects the SWAP states; otherwise cmd=11 maps to ST_ILL.
package regsel_pkg;

   localparam logic [1:0] CMD_MOV  = 2'b00;
   localparam logic [1:0] CMD_ALU1 = 2'b01;
   localparam logic [1:0] CMD_ALU2 = 2'b10;
   localparam logic [1:0] CMD_SWAP = 2'b11;

   localparam logic [1:0] SRC_USEQ = 2'b00;
   localparam logic [1:0] SRC_OP0  = 2'b01;
   localparam logic [1:0] SRC_OP1  = 2'b10;
   localparam logic [1:0] SRC_OP2  = 2'b11;

   localparam logic LSRC_USEQ = 1'b0;
   localparam logic LSRC_OP0  = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_XFER,
      ST_RDA,
      ST_RDB,
      ST_WB,
`ifdef REGSEL_SEQ_SWAP_EN
      ST_TMP,
      ST_MOVE,
      ST_REST
`else
      ST_ILL
`endif
   } state_t;

endpackage

// File: rtl/regsel_seq_decode.sv
// rtl/regsel_seq_decode.sv - Moore decode from sequencer state to regSel strobes and selects
// REGSEL_SEQ_SWAP_EN enables the SWAP states and the tmp register strobes.
module regsel_seq_decode
   import regsel_pkg::*;
(
   input  state_t     state,
`ifdef REGSEL_SEQ_SWAP_EN
   input  logic [2:0] op1,
`endif
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       oe,
   output logic       load,
   output logic [1:0] oeSourceSel,
   output logic       loadSourceSel,
   output logic [2:0] useqRegSelOe,
   output logic [2:0] useqRegSelLoad,
   output logic       aluALoad,
   output logic       aluBLoad,
   output logic       aluOe,
   output logic       tmpLoad,
   output logic       tmpOe
);

   always_comb begin
      busy           = (state != ST_IDLE);
      done           = 1'b0;
      err            = 1'b0;
      oe             = 1'b0;
      load           = 1'b0;
      oeSourceSel    = SRC_USEQ;
      loadSourceSel  = LSRC_USEQ;
      useqRegSelOe   = 3'd0;
      useqRegSelLoad = 3'd0;
      aluALoad       = 1'b0;
      aluBLoad       = 1'b0;
      aluOe          = 1'b0;
      tmpLoad        = 1'b0;
      tmpOe          = 1'b0;
      case (state)
         ST_XFER: begin
            oe            = 1'b1;
            oeSourceSel   = SRC_OP1;
            load          = 1'b1;
            loadSourceSel = LSRC_OP0;
            done          = 1'b1;
         end
         ST_RDA: begin
            oe          = 1'b1;
            oeSourceSel = SRC_OP1;
            aluALoad    = 1'b1;
         end
         ST_RDB: begin
            oe          = 1'b1;
            oeSourceSel = SRC_OP2;
            aluBLoad    = 1'b1;
         end
         ST_WB: begin
            aluOe         = 1'b1;
            load          = 1'b1;
            loadSourceSel = LSRC_OP0;
            done          = 1'b1;
         end
`ifdef REGSEL_SEQ_SWAP_EN
         ST_TMP: begin
            oe          = 1'b1;
            oeSourceSel = SRC_OP0;
            tmpLoad     = 1'b1;
         end
         ST_MOVE: begin
            oe            = 1'b1;
            oeSourceSel   = SRC_OP1;
            load          = 1'b1;
            loadSourceSel = LSRC_OP0;
         end
         // Restore op0's old value into op1 via the microsequencer load path
         ST_REST: begin
            tmpOe          = 1'b1;
            load           = 1'b1;
            loadSourceSel  = LSRC_USEQ;
            useqRegSelLoad = op1;
            done           = 1'b1;
         end
`else
         ST_ILL: begin
            done = 1'b1;
            err  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/regsel_seq.sv
// rtl/regsel_seq.sv - multi-cycle regSel command sequencer: FSM register and operand latches
// REGSEL_SEQ_SWAP_EN enables the SWAP command; otherwise cmd=11 reports err.
module regsel_seq
   import regsel_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] cmd,
   input  logic [2:0] op0_in,
   input  logic [2:0] op1_in,
   input  logic [2:0] op2_in,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [2:0] op0,
   output logic [2:0] op1,
   output logic [2:0] op2,
   output logic       oe,
   output logic       load,
   output logic [1:0] oeSourceSel,
   output logic       loadSourceSel,
   output logic [2:0] useqRegSelOe,
   output logic [2:0] useqRegSelLoad,
   output logic       aluALoad,
   output logic       aluBLoad,
   output logic       aluOe,
   output logic       tmpLoad,
   output logic       tmpOe
);

   state_t     state;
   state_t     state_next;
   logic [1:0] cmd_q;
   logic       accept;

   assign accept = (state == ST_IDLE) && start;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cmd_q <= CMD_MOV;
         op0   <= 3'd0;
         op1   <= 3'd0;
         op2   <= 3'd0;
      end else begin
         state <= state_next;
         if (accept) begin
            cmd_q <= cmd;
            op0   <= op0_in;
            op1   <= op1_in;
            op2   <= op2_in;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               case (cmd)
                  CMD_MOV:  state_next = ST_XFER;
                  CMD_ALU1: state_next = ST_RDA;
                  CMD_ALU2: state_next = ST_RDA;
`ifdef REGSEL_SEQ_SWAP_EN
                  default:  state_next = ST_TMP;
`else
                  default:  state_next = ST_ILL;
`endif
               endcase
            end
         end
         // ALU1 and ALU2 share RDA and WB; only ALU2 reads a second operand
         ST_RDA:  state_next = (cmd_q == CMD_ALU2) ? ST_RDB : ST_WB;
         ST_RDB:  state_next = ST_WB;
`ifdef REGSEL_SEQ_SWAP_EN
         ST_TMP:  state_next = ST_MOVE;
         ST_MOVE: state_next = ST_REST;
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   regsel_seq_decode u_decode (
      .state          (state),
`ifdef REGSEL_SEQ_SWAP_EN
      .op1            (op1),
`endif
      .busy           (busy),
      .done           (done),
      .err            (err),
      .oe             (oe),
      .load           (load),
      .oeSourceSel    (oeSourceSel),
      .loadSourceSel  (loadSourceSel),
      .useqRegSelOe   (useqRegSelOe),
      .useqRegSelLoad (useqRegSelLoad),
      .aluALoad       (aluALoad),
      .aluBLoad       (aluBLoad),
      .aluOe          (aluOe),
      .tmpLoad        (tmpLoad),
      .tmpOe          (tmpOe)
   );

endmodule

// File: tb/tb_regsel_seq.sv
// tb/tb_regsel_seq.sv - table-driven scoreboard bench for regsel_seq with a regSel/datapath model
// Expectations follow REGSEL_SEQ_SWAP_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_regsel_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic [2:0] op0_in = 3'd0, op1_in = 3'd0, op2_in = 3'd0;
   logic       busy, done, err, oe, load, loadSourceSel;
   logic [2:0] op0, op1, op2, useqRegSelOe, useqRegSelLoad;
   logic [1:0] oeSourceSel;
   logic       aluALoad, aluBLoad, aluOe, tmpLoad, tmpOe;

   regsel_seq dut (
      .clk(clk), .reset(reset), .start(start), .cmd(cmd),
      .op0_in(op0_in), .op1_in(op1_in), .op2_in(op2_in),
      .busy(busy), .done(done), .err(err),
      .op0(op0), .op1(op1), .op2(op2),
      .oe(oe), .load(load), .oeSourceSel(oeSourceSel), .loadSourceSel(loadSourceSel),
      .useqRegSelOe(useqRegSelOe), .useqRegSelLoad(useqRegSelLoad),
      .aluALoad(aluALoad), .aluBLoad(aluBLoad), .aluOe(aluOe),
      .tmpLoad(tmpLoad), .tmpOe(tmpOe)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       busy, done, err, oe, load;
      logic [1:0] oe_sel;
      logic       load_sel;
      logic [2:0] useq_oe, useq_load;
      logic       alu_a, alu_b, alu_oe, tmp_load, tmp_oe;
      logic [2:0] op0, op1, op2;
   } snap_t;

   typedef struct {
      logic [1:0] cmd;
      logic [2:0] o0, o1, o2;
      int         cycles;
   } vec_t;

   int    checks = 0;
   int    errors = 0;
   snap_t sb[$];
   logic [7:0] regs[8];
   logic [7:0] exp_regs[8];
   logic [7:0] tmp_r, alu_a_r, alu_b_r;

`ifdef REGSEL_SEQ_SWAP_EN
   localparam int SWAP_CYCLES = 3;
`else
   localparam int SWAP_CYCLES = 1;
`endif

   function automatic snap_t sample();
      snap_t s;
      s.busy = busy; s.done = done; s.err = err; s.oe = oe; s.load = load;
      s.oe_sel = oeSourceSel; s.load_sel = loadSourceSel;
      s.useq_oe = useqRegSelOe; s.useq_load = useqRegSelLoad;
      s.alu_a = aluALoad; s.alu_b = aluBLoad; s.alu_oe = aluOe;
      s.tmp_load = tmpLoad; s.tmp_oe = tmpOe;
      s.op0 = op0; s.op1 = op1; s.op2 = op2;
      return s;
   endfunction

   function automatic snap_t idle_snap(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
      snap_t r = '0;
      r.op0 = a; r.op1 = b; r.op2 = d;
      return r;
   endfunction

   // Reference behaviour of busy cycle s of command c
   function automatic snap_t model(input logic [1:0] c, input int s,
                                  input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
      snap_t r = idle_snap(a, b, d);
      r.busy = 1'b1;
      case (c)
         2'b00: begin
            r.oe = 1; r.oe_sel = 2'b10; r.load = 1; r.load_sel = 1; r.done = 1;
         end
         2'b01, 2'b10: begin
            if (s == 0) begin
               r.oe = 1; r.oe_sel = 2'b10; r.alu_a = 1;
            end else if (c == 2'b10 && s == 1) begin
               r.oe = 1; r.oe_sel = 2'b11; r.alu_b = 1;
            end else begin
               r.alu_oe = 1; r.load = 1; r.load_sel = 1; r.done = 1;
            end
         end
         default: begin
`ifdef REGSEL_SEQ_SWAP_EN
            if (s == 0) begin
               r.oe = 1; r.oe_sel = 2'b01; r.tmp_load = 1;
            end else if (s == 1) begin
               r.oe = 1; r.oe_sel = 2'b10; r.load = 1; r.load_sel = 1;
            end else begin
               r.tmp_oe = 1; r.load = 1; r.load_sel = 0; r.useq_load = b; r.done = 1;
            end
`else
            r.done = 1; r.err = 1;
`endif
         end
      endcase
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_snap(input string name, input snap_t act, input snap_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (busy done err oe load oesel lsel uoe uld aa ab ao tl to op0 op1 op2)",
                  name, act, exp);
      end
   endtask

   function automatic logic [2:0] oe_reg(input snap_t s);
      case (s.oe_sel)
         2'b00:   return s.useq_oe;
         2'b01:   return s.op0;
         2'b10:   return s.op1;
         default: return s.op2;
      endcase
   endfunction

   // One cycle of the regSel bus plus ALU/tmp latches, driven by the sampled strobes
   task automatic dp_step(input snap_t s);
      logic [7:0] bus;
      if (s.oe)          bus = regs[oe_reg(s)];
      else if (s.tmp_oe) bus = tmp_r;
      else if (s.alu_oe) bus = alu_a_r + alu_b_r;
      else               bus = 8'h00;
      if (s.tmp_load) tmp_r = bus;
      if (s.alu_a)    alu_a_r = bus;
      if (s.alu_b)    alu_b_r = bus;
      if (s.load)     regs[s.load_sel ? s.op0 : s.useq_load] = bus;
   endtask

   task automatic run_cmd(input vec_t v);
      snap_t s, e;
      int nb;
      logic [7:0] t, e8;
      for (int i = 0; i < 8; i++) exp_regs[i] = regs[i];
      case (v.cmd)
         2'b00: exp_regs[v.o0] = regs[v.o1];
         2'b01: exp_regs[v.o0] = regs[v.o1];
         2'b10: exp_regs[v.o0] = regs[v.o1] + regs[v.o2];
         default: begin
`ifdef REGSEL_SEQ_SWAP_EN
            t = regs[v.o0];
            exp_regs[v.o0] = regs[v.o1];
            exp_regs[v.o1] = t;
`endif
         end
      endcase
      alu_b_r = 8'h00;
      @(negedge clk);
      start = 1'b1; cmd = v.cmd; op0_in = v.o0; op1_in = v.o1; op2_in = v.o2;
      for (int i = 0; i < v.cycles; i++) sb.push_back(model(v.cmd, i, v.o0, v.o1, v.o2));
      sb.push_back(idle_snap(v.o0, v.o1, v.o2));
      nb = 0;
      @(negedge clk);
      start = 1'b0; op0_in = ~v.o0; op1_in = ~v.o1; op2_in = ~v.o2;
      while (sb.size() > 0) begin
         s = sample();
         e = sb.pop_front();
         chk_snap($sformatf("cmd%0d_cycle%0d", v.cmd, nb), s, e);
         if (s.busy) nb++;
         if (v.cmd == 2'b00 && s.busy) begin
            t  = 8'h00; if (s.oe) t[oe_reg(s)] = 1'b1;
            e8 = 8'h01 << v.o1;
            chk("mov_regOes", {24'h0, t}, {24'h0, e8});
            t  = 8'hFF; if (s.load) t[s.load_sel ? s.op0 : s.useq_load] = 1'b0;
            e8 = ~(8'h01 << v.o0);
            chk("mov_regNotLoads", {24'h0, t}, {24'h0, e8});
         end
         dp_step(s);
         if (sb.size() > 0) @(negedge clk);
      end
      chk($sformatf("cmd%0d_busy_cycles", v.cmd), nb, v.cycles);
      for (int i = 0; i < 8; i++)
         chk($sformatf("cmd%0d_reg%0d", v.cmd, i), {24'h0, regs[i]}, {24'h0, exp_regs[i]});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      vecs[0] = '{2'b00, 3'd1, 3'd3, 3'd0, 1};
      vecs[1] = '{2'b10, 3'd2, 3'd3, 3'd7, 3};
      vecs[2] = '{2'b11, 3'd4, 3'd5, 3'd0, SWAP_CYCLES};
      vecs[3] = '{2'b01, 3'd6, 3'd0, 3'd2, 2};
      vecs[4] = '{2'b00, 3'd7, 3'd7, 3'd7, 1};
      vecs[5] = '{2'b10, 3'd0, 3'd0, 3'd0, 3};
      vecs[6] = '{2'b11, 3'd3, 3'd3, 3'd1, SWAP_CYCLES};
      for (int i = 0; i < 8; i++) regs[i] = 8'h10 + 8'(i * 19);
      tmp_r = 8'h00; alu_a_r = 8'h00; alu_b_r = 8'h00;

      #1 reset = 1'b1;
      #1 chk_snap("reset_state", sample(), idle_snap(3'd0, 3'd0, 3'd0));
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_snap("after_reset_idle", sample(), idle_snap(3'd0, 3'd0, 3'd0));

      for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

      // start held high during ALU1 with operand inputs changing
      @(negedge clk);
      start = 1'b1; cmd = 2'b01; op0_in = 3'd1; op1_in = 3'd2; op2_in = 3'd3;
      @(negedge clk);
      chk_snap("hold_rda", sample(), model(2'b01, 0, 3'd1, 3'd2, 3'd3));
      cmd = 2'b00; op0_in = 3'd6; op1_in = 3'd5; op2_in = 3'd4;
      @(negedge clk);
      chk_snap("hold_wb", sample(), model(2'b01, 1, 3'd1, 3'd2, 3'd3));
      @(negedge clk);
      chk_snap("hold_idle_gap", sample(), idle_snap(3'd1, 3'd2, 3'd3));
      @(negedge clk);
      chk_snap("hold_next_mov", sample(), model(2'b00, 0, 3'd6, 3'd5, 3'd4));
      start = 1'b0;
      @(negedge clk);
      chk_snap("hold_end_idle", sample(), idle_snap(3'd6, 3'd5, 3'd4));

      // asynchronous reset while ALU2 is in RDB
      @(negedge clk);
      start = 1'b1; cmd = 2'b10; op0_in = 3'd2; op1_in = 3'd3; op2_in = 3'd7;
      @(negedge clk);
      start = 1'b0;
      chk_snap("rst_rda", sample(), model(2'b10, 0, 3'd2, 3'd3, 3'd7));
      @(negedge clk);
      chk_snap("rst_rdb", sample(), model(2'b10, 1, 3'd2, 3'd3, 3'd7));
      #1 reset = 1'b1;
      #1 chk_snap("rst_async", sample(), idle_snap(3'd0, 3'd0, 3'd0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_snap("rst_released_idle", sample(), idle_snap(3'd0, 3'd0, 3'd0));
      run_cmd(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
